ps2_key_decoder: RTL and testbench

- Parametrised PS/2 scancode decoder between PS2_Controller (received_data/received_data_en) and game/system logic.
- Collapses set-2 prefix sequences (E0, F0, E0 F0) into single make/break events.
- Events are buffered in a first-word-fall-through FIFO with a valid/ready pop handshake.
- Also tracks a held-key bitmap for a configurable key set, with optional typematic-repeat suppression and a prefix timeout.
- Supersedes the single-register keycode/key_make/key_ext path; its last_* outputs feed the debug hex digits.

---
 rtl/ps2_key_decoder.sv | 164 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder: folds E0/F0 prefixes into make/break events,
// queues them in a FWFT FIFO and tracks a held-key bitmap for a configured key set.
module ps2_key_decoder #(
  parameter int                    FIFO_DEPTH      = 8,
  parameter int                    NUM_KEYS        = 4,
  parameter logic [9*NUM_KEYS-1:0] KEYMAP          = {9'h174, 9'h16B, 9'h172, 9'h175},
  parameter int                    SUPPRESS_REPEAT = 1,
  parameter int                    TIMEOUT_CYCLES  = 2500000
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          key_en,
  input  logic [7:0]                    key_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_make,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic                          seq_timeout,
  output logic [NUM_KEYS-1:0]           key_held,
  output logic [7:0]                    last_code,
  output logic                          last_make,
  output logic                          last_ext,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tmo_cnt;
  logic          dropped;
  logic          emit, emit_ext, emit_make;
  logic [NUM_KEYS-1:0] match;
  logic          suppress, push, push_ok, pop, full;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  // Acks, BAT results, echo, pause prefix and error bytes carry no key meaning.
  always_comb begin
    dropped = 1'b0;
    case (key_data)
      8'hFA, 8'hFE, 8'hAA, 8'hEE, 8'hE1, 8'h00, 8'hFF: dropped = 1'b1;
      default: dropped = 1'b0;
    endcase
  end

  always_comb begin
    state_nx  = state;
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_make = 1'b0;
    if (key_en) begin
      if (key_data == 8'hE0) begin
        state_nx = S_EXT;
      end else if (key_data == 8'hF0) begin
        state_nx = (state == S_EXT) ? S_EXT_BRK : S_BRK;
      end else begin
        state_nx = S_IDLE;
        if (!dropped) begin
          emit      = 1'b1;
          emit_ext  = (state == S_EXT) || (state == S_EXT_BRK);
          emit_make = (state == S_IDLE) || (state == S_EXT);
        end
      end
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match[i] = (KEYMAP[9*i +: 9] == {emit_ext, key_data});
    end
  end

  // A make for a tracked key that is already down is a typematic repeat.
  assign suppress = (SUPPRESS_REPEAT != 0) && emit_make && (|(match & key_held));
  assign push     = emit && !suppress;

  assign evt_valid  = (count != '0);
  assign full       = (count == FULL_COUNT);
  assign pop        = evt_valid && evt_ready;
  assign push_ok    = push && (!full || pop);
  assign {evt_ext, evt_make, evt_code} = mem[rd_ptr];
  assign fifo_count = count;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      tmo_cnt     <= '0;
      seq_timeout <= 1'b0;
      key_held    <= '0;
      last_code   <= 8'h00;
      last_make   <= 1'b0;
      last_ext    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      seq_timeout <= 1'b0;
      if (key_en) begin
        state   <= state_nx;
        tmo_cnt <= '0;
      end else if (state != S_IDLE) begin
        if (tmo_cnt == TMO_LAST) begin
          state       <= S_IDLE;
          tmo_cnt     <= '0;
          seq_timeout <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
      if (emit) begin
        last_code <= key_data;
        last_make <= emit_make;
        last_ext  <= emit_ext;
        for (int i = 0; i < NUM_KEYS; i++) begin
          if (match[i]) key_held[i] <= emit_make;
        end
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // On a full FIFO with a pop, wr_ptr equals rd_ptr: the popped slot is reused.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {emit_ext, emit_make, key_data};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: prefix-flag model with an event queue checked every
// cycle, plus directed literal checks from the test plan.
module tb_ps2_key_decoder;

  localparam int          DEPTH = 8;
  localparam int          TMO   = 16;
  localparam logic [35:0] KMAP  = {9'h174, 9'h16B, 9'h172, 9'h175};

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       key_en = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       evt_ready = 1'b0;
  logic       clr_overflow = 1'b0;

  logic       evt_valid, evt_ext, evt_make, overflow, seq_timeout;
  logic [7:0] evt_code, last_code;
  logic       last_make, last_ext;
  logic [3:0] fifo_count, key_held;
  logic [1:0] dbg_state;

  logic       r_valid, r_ext, r_make, r_ovf, r_tmo, r_lmake, r_lext;
  logic [7:0] r_code, r_lcode;
  logic [3:0] r_count, r_held;
  logic [1:0] r_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .NUM_KEYS(4), .KEYMAP(KMAP),
                    .SUPPRESS_REPEAT(1), .TIMEOUT_CYCLES(TMO)) u_dut (
    .clk(clk), .resetn(resetn), .key_en(key_en), .key_data(key_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_make(evt_make), .fifo_count(fifo_count),
    .overflow(overflow), .clr_overflow(clr_overflow), .seq_timeout(seq_timeout),
    .key_held(key_held), .last_code(last_code), .last_make(last_make),
    .last_ext(last_ext), .dbg_state(dbg_state)
  );

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .NUM_KEYS(4), .KEYMAP(KMAP),
                    .SUPPRESS_REPEAT(0), .TIMEOUT_CYCLES(TMO)) u_dut_rep (
    .clk(clk), .resetn(resetn), .key_en(key_en), .key_data(key_data),
    .evt_valid(r_valid), .evt_ready(evt_ready), .evt_code(r_code),
    .evt_ext(r_ext), .evt_make(r_make), .fifo_count(r_count),
    .overflow(r_ovf), .clr_overflow(clr_overflow), .seq_timeout(r_tmo),
    .key_held(r_held), .last_code(r_lcode), .last_make(r_lmake),
    .last_ext(r_lext), .dbg_state(r_state)
  );

  // ---------------- model: pending-prefix flags + event queue ----------------
  logic [9:0] m_q[$];            // {ext, make, code}
  bit         m_ext, m_brk;
  int         m_idle;
  bit         m_ov, m_tmo;
  logic [3:0] m_held;
  logic [7:0] m_lcode;
  bit         m_lmake, m_lext;

  function automatic bit is_dropped(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hFE) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hE1) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  always @(posedge clk or negedge resetn) begin : model_step
    bit         pop, have, e_ext, e_make, sup;
    logic [7:0] e_code;
    if (!resetn) begin
      m_q.delete();
      m_ext = 0; m_brk = 0; m_idle = 0; m_ov = 0; m_tmo = 0;
      m_held = '0; m_lcode = '0; m_lmake = 0; m_lext = 0;
    end else begin
      pop = (m_q.size() > 0) && evt_ready;
      have = 0; e_ext = 0; e_make = 0; e_code = '0; m_tmo = 0;
      if (key_en) begin
        m_idle = 0;
        if (key_data == 8'hE0) begin
          m_ext = 1; m_brk = 0;
        end else if (key_data == 8'hF0) begin
          m_ext = m_ext && !m_brk;
          m_brk = 1;
        end else begin
          if (!is_dropped(key_data)) begin
            have = 1; e_ext = m_ext; e_make = !m_brk; e_code = key_data;
          end
          m_ext = 0; m_brk = 0;
        end
      end else if (m_ext || m_brk) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_ext = 0; m_brk = 0; m_idle = 0; m_tmo = 1;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (clr_overflow) m_ov = 0;
      if (have) begin
        m_lcode = e_code; m_lmake = e_make; m_lext = e_ext;
        sup = 0;
        for (int i = 0; i < 4; i++)
          if (KMAP[9*i +: 9] == {e_ext, e_code} && e_make && m_held[i]) sup = 1;
        for (int i = 0; i < 4; i++)
          if (KMAP[9*i +: 9] == {e_ext, e_code}) m_held[i] = e_make;
        if (!sup) begin
          if (m_q.size() < DEPTH) m_q.push_back({e_ext, e_make, e_code});
          else m_ov = 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cyc_valid", 32'(evt_valid), 32'(m_q.size() > 0));
    check("cyc_count", 32'(fifo_count), 32'(m_q.size()));
    if (m_q.size() > 0) begin
      check("cyc_head", {22'd0, evt_ext, evt_make, evt_code}, {22'd0, m_q[0]});
    end
    check("cyc_overflow", 32'(overflow), 32'(m_ov));
    check("cyc_timeout", 32'(seq_timeout), 32'(m_tmo));
    check("cyc_held", 32'(key_held), 32'(m_held));
    check("cyc_last", {22'd0, last_ext, last_make, last_code}, {22'd0, m_lext, m_lmake, m_lcode});
    check("cyc_idle", 32'(dbg_state == 2'd0), 32'(!(m_ext || m_brk)));
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    key_en = 1'b1;
    key_data = b;
    tick(1);
    key_en = 1'b0;
  endtask

  task automatic drain();
    evt_ready = 1'b1;
    tick(12);
    evt_ready = 1'b0;
  endtask

  initial begin
    tick(3);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_last", {24'd0, last_code}, 32'd0);
    resetn = 1'b1;
    tick(2);

    // Plain make, then break, held in the FIFO.
    send(8'h1C);
    check("t1_valid_lat", 32'(evt_valid), 32'd1);
    send(8'hF0);
    send(8'h1C);
    check("t1_count", 32'(fifo_count), 32'd2);
    check("t1_head", {22'd0, evt_ext, evt_make, evt_code}, {22'd0, 2'b01, 8'h1C});
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("t1_second", {22'd0, evt_ext, evt_make, evt_code}, {22'd0, 2'b00, 8'h1C});
    drain();

    // Extended tracked key press and release.
    send(8'hE0); send(8'h75);
    check("t2_held_on", 32'(key_held), 32'b0001);
    check("t2_head", {22'd0, evt_ext, evt_make, evt_code}, {22'd0, 2'b11, 8'h75});
    send(8'hE0); send(8'hF0); send(8'h75);
    check("t2_held_off", 32'(key_held), 32'b0000);
    check("t2_last", {22'd0, last_ext, last_make, last_code}, {22'd0, 2'b10, 8'h75});
    check("t2_count", 32'(fifo_count), 32'd2);
    drain();

    // Typematic repeat.
    for (int i = 0; i < 3; i++) begin
      send(8'hE0); send(8'h75);
      check("t3_last_code", {24'd0, last_code}, 32'h75);
    end
    check("t3_count_sup", 32'(fifo_count), 32'd1);
    check("t3_count_rep", 32'(r_count), 32'd3);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain();

    // Overflow then ordered drain.
    for (int i = 0; i < 9; i++) send(8'h1C + 8'(i));
    check("t4_count", 32'(fifo_count), 32'd8);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_head", {24'd0, evt_code}, 32'h1C);
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t4_order", {24'd0, evt_code}, 32'h1C + 32'(i));
      tick(1);
    end
    evt_ready = 1'b0;
    check("t4_empty", 32'(evt_valid), 32'd0);
    check("t4_ovf_kept", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 32'd0);

    // Prefix timeout.
    send(8'hE0);
    for (int c = 1; c <= TMO; c++) begin
      tick(1);
      if (c < TMO) check("t5_no_pulse", 32'(seq_timeout), 32'd0);
    end
    check("t5_pulse", 32'(seq_timeout), 32'd1);
    check("t5_idle", 32'(dbg_state), 32'd0);
    tick(1);
    check("t5_pulse_end", 32'(seq_timeout), 32'd0);
    send(8'h75);
    check("t5_event", {22'd0, evt_ext, evt_make, evt_code}, {22'd0, 2'b01, 8'h75});
    drain();

    // Simultaneous push and pop on a full FIFO.
    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i));
    check("t6_full", 32'(fifo_count), 32'd8);
    key_en = 1'b1; key_data = 8'h38; evt_ready = 1'b1;
    tick(1);
    key_en = 1'b0; evt_ready = 1'b0;
    check("t6_count", 32'(fifo_count), 32'd8);
    check("t6_no_ovf", 32'(overflow), 32'd0);
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t6_order", {24'd0, evt_code}, 32'h31 + 32'(i));
      tick(1);
    end
    evt_ready = 1'b0;

    // Reset in the middle of a break sequence.
    send(8'hE0); send(8'h75); send(8'h1C); send(8'hE0); send(8'hF0);
    check("t7_pre_held", 32'(key_held), 32'b0001);
    resetn = 1'b0;
    #2;
    check("t7_valid", 32'(evt_valid), 32'd0);
    check("t7_count", 32'(fifo_count), 32'd0);
    check("t7_held", 32'(key_held), 32'd0);
    check("t7_last", {22'd0, last_ext, last_make, last_code}, 32'd0);
    check("t7_state", 32'(dbg_state), 32'd0);
    tick(2);
    resetn = 1'b1;
    tick(1);
    send(8'h75);
    check("t7_after", {22'd0, evt_ext, evt_make, evt_code}, {22'd0, 2'b01, 8'h75});
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
